// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared constants for the single-bus datapath
// Opcodes, branch condition codes, IR field positions and memory geometry.
package datapath_pkg;

   localparam int MEM_DEPTH = 512;
   localparam int MEM_AW    = 9;

   localparam int IR_RA_MSB = 26;
   localparam int IR_RA_LSB = 23;
   localparam int IR_RB_MSB = 22;
   localparam int IR_RB_LSB = 19;
   localparam int IR_RC_MSB = 18;
   localparam int IR_RC_LSB = 15;
   localparam int IR_C2_MSB = 20;
   localparam int IR_C2_LSB = 19;
   localparam int IR_C_MSB  = 18;

   typedef enum logic [4:0] {
      OP_LD   = 5'b00000,
      OP_LDI  = 5'b00001,
      OP_ST   = 5'b00010,
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_SHR  = 5'b00101,
      OP_SHRA = 5'b00110,
      OP_SHL  = 5'b00111,
      OP_ROR  = 5'b01000,
      OP_ROL  = 5'b01001,
      OP_AND  = 5'b01010,
      OP_OR   = 5'b01011,
      OP_ADDI = 5'b01100,
      OP_ANDI = 5'b01101,
      OP_ORI  = 5'b01110,
      OP_DIV  = 5'b01111,
      OP_MUL  = 5'b10000,
      OP_NEG  = 5'b10001,
      OP_NOT  = 5'b10010
   } op_e;

   typedef enum logic [1:0] {
      C2_EQ0 = 2'b00,
      C2_NE0 = 2'b01,
      C2_GE0 = 2'b10,
      C2_LT0 = 2'b11
   } c2_e;

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational ALU, A=Y, B=bus, 64-bit result for Z
// Multiply/divide exist only when DATAPATH_MULDIV_EN is defined.
module datapath_alu
   import datapath_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [4:0]  i_opcode,
   input  logic        i_inc_pc,
   output logic [63:0] o_result
);

   logic [4:0]  w_sh;
   logic [63:0] w_dbl;
   logic [63:0] w_ror;
   logic [63:0] w_rol;

   assign w_sh  = i_b[4:0];
   // Rotates fall out of shifting a doubled copy of A.
   assign w_dbl = {i_a, i_a};
   assign w_ror = w_dbl >> w_sh;
   assign w_rol = w_dbl << w_sh;

`ifdef DATAPATH_MULDIV_EN
   logic [63:0] w_prod;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_prod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_quot = (i_b == '0) ? '0 : $signed(i_a) / $signed(i_b);
   assign w_rem  = (i_b == '0) ? '0 : $signed(i_a) % $signed(i_b);
`endif

   always_comb begin
      o_result = '0;
      if (i_inc_pc) begin
         o_result = {32'd0, i_b + 32'd1};
      end else begin
         case (i_opcode)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: o_result[31:0] = i_a + i_b;
            OP_SUB:                 o_result[31:0] = i_a - i_b;
            OP_SHR:                 o_result[31:0] = i_a >> w_sh;
            OP_SHRA:                o_result[31:0] = $signed(i_a) >>> w_sh;
            OP_SHL:                 o_result[31:0] = i_a << w_sh;
            OP_ROR:                 o_result[31:0] = w_ror[31:0];
            OP_ROL:                 o_result[31:0] = w_rol[63:32];
            OP_AND, OP_ANDI:        o_result[31:0] = i_a & i_b;
            OP_OR, OP_ORI:          o_result[31:0] = i_a | i_b;
            OP_NEG:                 o_result[31:0] = 32'd0 - i_b;
            OP_NOT:                 o_result[31:0] = ~i_b;
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:                 o_result = w_prod;
            OP_DIV:                 o_result = {w_rem, w_quot};
`endif
            default:                o_result = '0;
         endcase
      end
   end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - Mini SRC style single-bus CPU datapath with internal memory
// Optional multiply/divide in the ALU is enabled by DATAPATH_MULDIV_EN.
module datapath
   import datapath_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_clear,
   input  logic        i_read,
   input  logic        i_write,
   input  logic        i_inc_pc,
   input  logic [4:0]  i_opcode,
   input  logic        i_gra,
   input  logic        i_grb,
   input  logic        i_grc,
   input  logic        i_rin,
   input  logic        i_rout,
   input  logic        i_baout,
   input  logic        i_hi_in,
   input  logic        i_lo_in,
   input  logic        i_y_in,
   input  logic        i_z_in,
   input  logic        i_pc_in,
   input  logic        i_ir_in,
   input  logic        i_mar_in,
   input  logic        i_mdr_in,
   input  logic        i_inport_in,
   input  logic        i_outport_in,
   input  logic        i_con_in,
   input  logic        i_hi_out,
   input  logic        i_lo_out,
   input  logic        i_y_out,
   input  logic        i_zhigh_out,
   input  logic        i_zlow_out,
   input  logic        i_pc_out,
   input  logic        i_mar_out,
   input  logic        i_mdr_out,
   input  logic        i_inport_out,
   input  logic        i_outport_out,
   input  logic        i_c_out,
   input  logic [31:0] i_inport_data,
   output logic [31:0] o_ir,
   output logic        o_con
);

   logic [31:0] r_regs [16];
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_mar;
   logic [31:0] r_mdr;
   logic [31:0] r_y;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_inport;
   logic [31:0] r_outport;
   logic [63:0] r_z;
   logic        r_con;
   logic [31:0] r_mem [MEM_DEPTH];

   logic [3:0]        w_idx;
   logic [31:0]       w_sel_reg;
   logic [31:0]       w_c_sext;
   logic [31:0]       w_bus;
   logic [31:0]       w_mdr_d;
   logic [63:0]       w_alu;
   logic [MEM_AW-1:0] w_addr;
   logic              w_cond;

   assign w_idx = ({4{i_gra}} & r_ir[IR_RA_MSB:IR_RA_LSB])
                | ({4{i_grb}} & r_ir[IR_RB_MSB:IR_RB_LSB])
                | ({4{i_grc}} & r_ir[IR_RC_MSB:IR_RC_LSB]);
   assign w_sel_reg = r_regs[w_idx];
   assign w_c_sext  = {{(31 - IR_C_MSB){r_ir[IR_C_MSB]}}, r_ir[IR_C_MSB:0]};

   // Drivers should be one-hot; the chain order resolves accidental overlap.
   always_comb begin
      w_bus = '0;
      if (i_rout)              w_bus = w_sel_reg;
      else if (i_baout)        w_bus = (w_idx == 4'd0) ? 32'd0 : w_sel_reg;
      else if (i_hi_out)       w_bus = r_hi;
      else if (i_lo_out)       w_bus = r_lo;
      else if (i_y_out)        w_bus = r_y;
      else if (i_zhigh_out)    w_bus = r_z[63:32];
      else if (i_zlow_out)     w_bus = r_z[31:0];
      else if (i_pc_out)       w_bus = r_pc;
      else if (i_mar_out)      w_bus = r_mar;
      else if (i_mdr_out)      w_bus = r_mdr;
      else if (i_inport_out)   w_bus = r_inport;
      else if (i_outport_out)  w_bus = r_outport;
      else if (i_c_out)        w_bus = w_c_sext;
   end

   assign w_addr  = r_mar[MEM_AW-1:0];
   assign w_mdr_d = i_read ? r_mem[w_addr] : w_bus;

   datapath_alu u_alu (
      .i_a      (r_y),
      .i_b      (w_bus),
      .i_opcode (i_opcode),
      .i_inc_pc (i_inc_pc),
      .o_result (w_alu)
   );

   always_comb begin
      w_cond = 1'b0;
      case (r_ir[IR_C2_MSB:IR_C2_LSB])
         C2_EQ0:  w_cond = (w_bus == 32'd0);
         C2_NE0:  w_cond = (w_bus != 32'd0);
         C2_GE0:  w_cond = ~w_bus[31];
         C2_LT0:  w_cond = w_bus[31];
         default: w_cond = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         for (int i = 0; i < 16; i++) r_regs[i] <= '0;
         r_pc      <= '0;
         r_ir      <= '0;
         r_mar     <= '0;
         r_mdr     <= '0;
         r_y       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_inport  <= '0;
         r_outport <= '0;
         r_z       <= '0;
         r_con     <= 1'b0;
      end else begin
         if (i_rin)        r_regs[w_idx] <= w_bus;
         if (i_pc_in)      r_pc      <= w_bus;
         if (i_ir_in)      r_ir      <= w_bus;
         if (i_mar_in)     r_mar     <= w_bus;
         if (i_mdr_in)     r_mdr     <= w_mdr_d;
         if (i_y_in)       r_y       <= w_bus;
         if (i_hi_in)      r_hi      <= w_bus;
         if (i_lo_in)      r_lo      <= w_bus;
         if (i_z_in)       r_z       <= w_alu;
         if (i_inport_in)  r_inport  <= i_inport_data;
         if (i_outport_in) r_outport <= w_bus;
         if (i_con_in)     r_con     <= w_cond;
      end
   end

   // Memory keeps its contents across clear; the write uses MDR before any same-edge load.
   always_ff @(posedge i_clk) begin
      if (!i_clear && i_write) r_mem[w_addr] <= r_mdr;
   end

   assign o_ir  = r_ir;
   assign o_con = r_con;

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - self-checking bench for datapath with a behavioural model
`timescale 1ns/1ps
module tb_datapath;

   typedef struct packed {
      logic clear, rd, wr, inc, gra, grb, grc, rin, rout, baout;
      logic hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in, ip_in, op_in, con_in;
      logic hi_out, lo_out, y_out, zh_out, zl_out, pc_out, mar_out, mdr_out, ip_out, op_out, c_out;
   } ctl_t;

   logic        clk = 1'b0;
   ctl_t        c;
   logic [4:0]  opc;
   logic [31:0] ipd;
   logic [31:0] o_ir;
   logic        o_con;

   always #5 clk = ~clk;

   datapath dut (
      .i_clk(clk), .i_clear(c.clear), .i_read(c.rd), .i_write(c.wr), .i_inc_pc(c.inc),
      .i_opcode(opc), .i_gra(c.gra), .i_grb(c.grb), .i_grc(c.grc),
      .i_rin(c.rin), .i_rout(c.rout), .i_baout(c.baout),
      .i_hi_in(c.hi_in), .i_lo_in(c.lo_in), .i_y_in(c.y_in), .i_z_in(c.z_in),
      .i_pc_in(c.pc_in), .i_ir_in(c.ir_in), .i_mar_in(c.mar_in), .i_mdr_in(c.mdr_in),
      .i_inport_in(c.ip_in), .i_outport_in(c.op_in), .i_con_in(c.con_in),
      .i_hi_out(c.hi_out), .i_lo_out(c.lo_out), .i_y_out(c.y_out),
      .i_zhigh_out(c.zh_out), .i_zlow_out(c.zl_out), .i_pc_out(c.pc_out),
      .i_mar_out(c.mar_out), .i_mdr_out(c.mdr_out), .i_inport_out(c.ip_out),
      .i_outport_out(c.op_out), .i_c_out(c.c_out), .i_inport_data(ipd),
      .o_ir(o_ir), .o_con(o_con)
   );

   // Reference state
   logic [31:0] m_r [16];
   logic [31:0] m_mem [512];
   logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_ip, m_op;
   logic [63:0] m_z;
   logic        m_con;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;
   bit mem_en = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] m_idx();
      return (c.gra ? m_ir[26:23] : 4'd0) | (c.grb ? m_ir[22:19] : 4'd0) | (c.grc ? m_ir[18:15] : 4'd0);
   endfunction

   function automatic logic [31:0] m_bus();
      logic [3:0] k;
      k = m_idx();
      if (c.rout)   return m_r[k];
      if (c.baout)  return (k == 0) ? 32'd0 : m_r[k];
      if (c.hi_out) return m_hi;
      if (c.lo_out) return m_lo;
      if (c.y_out)  return m_y;
      if (c.zh_out) return m_z[63:32];
      if (c.zl_out) return m_z[31:0];
      if (c.pc_out) return m_pc;
      if (c.mar_out) return m_mar;
      if (c.mdr_out) return m_mdr;
      if (c.ip_out) return m_ip;
      if (c.op_out) return m_op;
      if (c.c_out)  return 32'($signed(m_ir[18:0]));
      return 32'd0;
   endfunction

   function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op, input logic inc);
      logic [31:0] r;
      int          n, ia, ib;
      longint      la, lb;
      if (inc) return {32'd0, b + 32'd1};
      n = int'(b[4:0]);
      r = a;
      case (op)
         5'd0, 5'd1, 5'd2, 5'd3, 5'd12: return {32'd0, a + b};
         5'd4:  return {32'd0, a - b};
         5'd5:  return {32'd0, a >> n};
         5'd6:  return {32'd0, 32'($signed(a) >>> n)};
         5'd7:  return {32'd0, a << n};
         5'd8:  begin repeat (n) r = {r[0], r[31:1]}; return {32'd0, r}; end
         5'd9:  begin repeat (n) r = {r[30:0], r[31]}; return {32'd0, r}; end
         5'd10, 5'd13: return {32'd0, a & b};
         5'd11, 5'd14: return {32'd0, a | b};
         5'd17: return {32'd0, 32'd0 - b};
         5'd18: return {32'd0, ~b};
`ifdef DATAPATH_MULDIV_EN
         5'd16: begin la = longint'($signed(a)); lb = longint'($signed(b)); return 64'(la * lb); end
         5'd15: begin
            ia = a; ib = b;
            if (ib == 0) return 64'd0;
            return {32'(ia % ib), 32'(ia / ib)};
         end
`endif
         default: return 64'd0;
      endcase
   endfunction

   // One clock: model updates from pre-edge state, DUT inputs are left as driven.
   task automatic step();
      logic [31:0] bus, mdr_d;
      logic [63:0] alu;
      logic [3:0]  k;
      logic        cond;
      @(posedge clk);
      k     = m_idx();
      bus   = m_bus();
      alu   = m_alu(m_y, bus, opc, c.inc);
      mdr_d = c.rd ? m_mem[m_mar[8:0]] : bus;
      case (m_ir[20:19])
         2'b00:   cond = (bus == 0);
         2'b01:   cond = (bus != 0);
         2'b10:   cond = ($signed(bus) >= 0);
         default: cond = ($signed(bus) < 0);
      endcase
      if (c.clear) begin
         for (int i = 0; i < 16; i++) m_r[i] = 0;
         {m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_ip, m_op} = '0;
         m_z = 0; m_con = 0;
      end else begin
         if (c.wr)     m_mem[m_mar[8:0]] = m_mdr;
         if (c.rin)    m_r[k] = bus;
         if (c.pc_in)  m_pc = bus;
         if (c.ir_in)  m_ir = bus;
         if (c.mar_in) m_mar = bus;
         if (c.mdr_in) m_mdr = mdr_d;
         if (c.y_in)   m_y = bus;
         if (c.hi_in)  m_hi = bus;
         if (c.lo_in)  m_lo = bus;
         if (c.z_in)   m_z = alu;
         if (c.ip_in)  m_ip = ipd;
         if (c.op_in)  m_op = bus;
         if (c.con_in) m_con = cond;
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 16; i++) cmp($sformatf("R%0d", i), 64'(dut.r_regs[i]), 64'(m_r[i]));
         cmp("PC", 64'(dut.r_pc), 64'(m_pc));
         cmp("IR", 64'(o_ir), 64'(m_ir));
         cmp("MAR", 64'(dut.r_mar), 64'(m_mar));
         cmp("MDR", 64'(dut.r_mdr), 64'(m_mdr));
         cmp("Y", 64'(dut.r_y), 64'(m_y));
         cmp("HI", 64'(dut.r_hi), 64'(m_hi));
         cmp("LO", 64'(dut.r_lo), 64'(m_lo));
         cmp("Z", dut.r_z, m_z);
         cmp("INPORT", 64'(dut.r_inport), 64'(m_ip));
         cmp("OUTPORT", 64'(dut.r_outport), 64'(m_op));
         cmp("CON", 64'(o_con), 64'(m_con));
         if (mem_en) cmp("MEM[MAR]", 64'(dut.r_mem[m_mar[8:0]]), 64'(m_mem[m_mar[8:0]]));
      end
   end

   initial begin
      logic [31:0] d;
      c = '0; opc = 0; ipd = 0;
      for (int i = 0; i < 512; i++) m_mem[i] = 0;

      c.clear = 1; step();
      chk_en = 1;
      cmp("reset PC", 64'(dut.r_pc), 64'd0);
      cmp("reset R7", 64'(dut.r_regs[7]), 64'd0);
      cmp("reset Z", dut.r_z, 64'd0);

      // Preload the whole memory through the inport, MAR and MDR
      for (int a = 0; a < 512; a++) begin
         d = (a == 0) ? 32'h0A00_0005 : $urandom;
         c = '0; c.ip_in = 1; c.wr = (a != 0); ipd = 32'(a); step();
         c = '0; c.ip_out = 1; c.mar_in = 1; c.ip_in = 1; ipd = d; step();
         c = '0; c.ip_out = 1; c.mdr_in = 1; step();
      end
      c = '0; c.wr = 1; step();
      mem_en = 1;

      // Fetch
      c = '0; c.pc_out = 1; c.mar_in = 1; c.inc = 1; c.z_in = 1; step();
      c = '0; c.zl_out = 1; c.pc_in = 1; c.rd = 1; c.mdr_in = 1; step();
      c = '0; c.mdr_out = 1; c.ir_in = 1; step();
      cmp("fetch PC", 64'(dut.r_pc), 64'd1);
      cmp("fetch MAR", 64'(dut.r_mar), 64'd0);
      cmp("fetch IR", 64'(o_ir), 64'h0A00_0005);

      // ldi R4,5
      c = '0; c.grb = 1; c.baout = 1; c.y_in = 1; step();
      cmp("ldi Y", 64'(dut.r_y), 64'd0);
      c = '0; c.c_out = 1; c.z_in = 1; opc = 5'b00011; step();
      cmp("ldi Z", dut.r_z, 64'd5);
      c = '0; c.zl_out = 1; c.gra = 1; c.rin = 1; step();
      cmp("ldi R4", 64'(dut.r_regs[4]), 64'd5);

      // Negative constant added to R2=10
      c = '0; c.ip_in = 1; ipd = 32'h0107_FFFF; step();
      c = '0; c.ip_out = 1; c.ir_in = 1; c.ip_in = 1; ipd = 32'd10; step();
      c = '0; c.ip_out = 1; c.gra = 1; c.rin = 1; step();
      cmp("R2", 64'(dut.r_regs[2]), 64'd10);
      c = '0; c.gra = 1; c.rout = 1; c.y_in = 1; step();
      c = '0; c.c_out = 1; c.z_in = 1; opc = 5'b00011; #1;
      cmp("C bus", 64'(dut.w_bus), 64'hFFFF_FFFF);
      step();
      cmp("add neg C", dut.r_z, 64'd9);

      // Store, write-with-MDRin, load
      c = '0; c.ip_in = 1; ipd = 32'h10; step();
      c = '0; c.ip_out = 1; c.mar_in = 1; c.ip_in = 1; ipd = 32'hDEAD_BEEF; step();
      c = '0; c.ip_out = 1; c.mdr_in = 1; c.ip_in = 1; ipd = 32'hCAFE_F00D; step();
      c = '0; c.wr = 1; step();
      cmp("store mem16", 64'(dut.r_mem[16]), 64'hDEAD_BEEF);
      c = '0; c.wr = 1; c.ip_out = 1; c.mdr_in = 1; step();
      cmp("wr+mdrin mem16", 64'(dut.r_mem[16]), 64'hDEAD_BEEF);
      cmp("wr+mdrin MDR", 64'(dut.r_mdr), 64'hCAFE_F00D);
      c = '0; c.rd = 1; c.mdr_in = 1; step();
      cmp("load MDR", 64'(dut.r_mdr), 64'hDEAD_BEEF);

      // Branch condition C2=01
      c = '0; c.ip_in = 1; ipd = 32'h0008_0000; step();
      c = '0; c.ip_out = 1; c.ir_in = 1; c.ip_in = 1; ipd = 32'd3; step();
      c = '0; c.ip_out = 1; c.con_in = 1; step();
      cmp("CON bus=3", 64'(o_con), 64'd1);
      c = '0; c.con_in = 1; step();
      cmp("CON bus=0", 64'(o_con), 64'd0);

      // Inport outranks Outport on the bus
      c = '0; c.ip_in = 1; ipd = 32'd7; step();
      c = '0; c.ip_out = 1; c.op_in = 1; c.ip_in = 1; ipd = 32'd5; step();
      c = '0; c.ip_out = 1; c.op_out = 1; c.y_in = 1; step();
      cmp("priority Y", 64'(dut.r_y), 64'd5);

      // mul / div of -6 by 4
      c = '0; c.ip_in = 1; ipd = 32'hFFFF_FFFA; step();
      c = '0; c.ip_out = 1; c.y_in = 1; c.ip_in = 1; ipd = 32'd4; step();
      c = '0; c.ip_out = 1; c.z_in = 1; opc = 5'b10000; step();
`ifdef DATAPATH_MULDIV_EN
      cmp("mul Z", dut.r_z, 64'hFFFF_FFFF_FFFF_FFE8);
`else
      cmp("mul Z", dut.r_z, 64'd0);
`endif
      c = '0; c.ip_out = 1; c.z_in = 1; opc = 5'b01111; step();
`ifdef DATAPATH_MULDIV_EN
      cmp("div Z", dut.r_z, 64'hFFFF_FFFE_FFFF_FFFF);
`else
      cmp("div Z", dut.r_z, 64'd0);
`endif

      // Clear mid-sequence beats every enable, including Write
      c = '0; c.ip_in = 1; ipd = 32'h55; step();
      c = '0; c.ip_out = 1; c.mdr_in = 1; step();
      c = '0; c.clear = 1; c.pc_out = 1; c.inc = 1; c.z_in = 1; c.pc_in = 1; c.wr = 1; c.rin = 1; step();
      cmp("clear PC", 64'(dut.r_pc), 64'd0);
      cmp("clear Z", dut.r_z, 64'd0);
      cmp("clear R4", 64'(dut.r_regs[4]), 64'd0);
      cmp("clear Y", 64'(dut.r_y), 64'd0);
      cmp("clear MDR", 64'(dut.r_mdr), 64'd0);
      cmp("clear keeps mem16", 64'(dut.r_mem[16]), 64'hDEAD_BEEF);

      // Random control strobes against the model
      for (int n = 0; n < 2500; n++) begin
         c = ctl_t'($urandom & $urandom & $urandom);
         c.clear = ($urandom_range(0, 99) == 0);
         opc = 5'($urandom_range(0, 31));
         ipd = $urandom;
         step();
      end
      c = '0; step();
      chk_en = 0;
      for (int a = 0; a < 512; a++) cmp($sformatf("final mem[%0d]", a), 64'(dut.r_mem[a]), 64'(m_mem[a]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
